// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO and models fixed
// mult/div latency with a down-counter, stalling dependent D-stage instructions.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic [63:0] mul_s, mul_u;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    mul_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    mul_u  = {32'b0, A} * {32'b0, B};
    res_hi = '0;
    res_lo = '0;
    case (op[1:0])
      2'd0: {res_hi, res_lo} = mul_s;
      2'd1: {res_hi, res_lo} = mul_u;
      2'd2: begin
        // Zero divisor and the INT_MIN/-1 overflow are resolved here so the
        // divider itself never sees an undefined case.
        if (B == 32'h0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = A;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'h0;
        end else begin
          res_lo = $signed(A) / $signed(B);
          res_hi = $signed(A) % $signed(B);
        end
      end
      default: begin
        if (B == 32'h0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = A;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              sh_hi_d = res_hi;
              sh_lo_d = res_lo;
              cnt_d   = op[1] ? DIV_N : MULT_N;
              busy_d  = 1'b1;
              state_d = RUN;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign md_stall = md_use_D & (busy_q | (start & (op <= 3'd3)));

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: issued mult/div ops queue their expected
// HI/LO and latency; a monitor checks each completion and HI/LO stability.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        md_use_D;
  logic        busy, md_stall;
  logic [31:0] HI, LO;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .md_use_D(md_use_D), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        rst_samp = 1'b0;
  logic        prev_busy = 1'b0;
  logic [31:0] snap_hi, snap_lo;
  int          bcnt;

  always @(posedge clk) rst_samp <= reset;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_samp) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && start) begin
        errors++;
        $display("FAIL protocol start_while_busy op=%0d", op);
      end
      if (busy && !prev_busy) begin
        snap_hi = HI;
        snap_lo = LO;
        bcnt    = 1;
      end else if (busy) begin
        bcnt++;
        chk("hold_hi", HI, snap_hi);
        chk("hold_lo", LO, snap_lo);
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion hi=%h lo=%h", HI, LO);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, HI, e.hi);
          chk({e.name, "_lo"}, LO, e.lo);
          chk({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cyc));
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div op and follow it to completion, checking md_stall
  // in the start cycle, every busy cycle, and the cycle after.
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int n, input logic use_d);
    exp_t e;
    int   k;
    e.hi = eh; e.lo = el; e.cyc = n; e.name = name;
    exp_q.push_back(e);
    md_use_D = use_d;
    start = 1'b1; op = o; A = a; B = b;
    #1;
    chk({name, "_stall_start"}, 32'(md_stall), 32'(use_d));
    cyc();
    start = 1'b0; op = 3'd6;
    k = 0;
    while (busy && k < 40) begin
      #1;
      chk({name, "_stall_busy"}, 32'(md_stall), 32'(use_d));
      cyc();
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout busy=%b expected=0", name, busy);
    end
    chk({name, "_stall_after"}, 32'(md_stall), 32'h0);
    md_use_D = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd5; md_use_D = 1'b0;
    cyc();
    cyc();
    reset = 1'b1; start = 1'b0; op = 3'd6;
    cyc();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);

    issue("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
    issue("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
    issue("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
    issue("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10, 1'b0);
    issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 1'b1);
    issue("div_zero", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 1'b0);
    issue("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0);

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = 3'd4; A = 32'h1234_5678;
    cyc();
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo_kept", LO, 32'd14);
    chk("mthi_busy", 32'(busy), 32'h0);
    op = 3'd5; A = 32'h9ABC_DEF0;
    cyc();
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", HI, 32'h1234_5678);
    chk("mtlo_busy", 32'(busy), 32'h0);
    start = 1'b0; op = 3'd7;
    cyc();

    // no-op commands leave everything alone
    start = 1'b1; op = 3'd6; A = 32'hDEAD_BEEF;
    cyc();
    start = 1'b0;
    chk("nop_busy", 32'(busy), 32'h0);
    chk("nop_hi", HI, 32'h1234_5678);

    // mid-run reset discards the in-flight result
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
    cyc();
    start = 1'b0; op = 3'd6;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hi", HI, 32'h0);
    chk("midrst_lo", LO, 32'h0);
    repeat (12) cyc();
    chk("midrst_lo_late", LO, 32'h0);
    chk("midrst_busy_late", 32'(busy), 32'h0);

    repeat (3) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
